hazard_ctrl_mc: RTL and testbench

//  Next-generation hazard controller for the 5-stage RV32 pipeline with L1 caches.
//  - Keeps EX-stage operand forwarding (MEM priority over WB) and load-use detection.
//  - Adds a programmable load-use penalty, I/D-cache miss stalls and a configurable

---
 rtl/hazard_ctrl_mc.sv | 165 ++++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: operand forwarding, load-use / cache-miss stalls and
// redirect flush control for the 5-stage RV32 pipeline, with perf counters.
module hazard_ctrl_mc #(
    parameter int LU_CYCLES   = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             regwen_mem_i,
    input  logic             regwen_wb_i,
    input  logic [31:0]      inst_ex_i,
    input  logic [31:0]      inst_mem_i,
    input  logic [31:0]      inst_wb_i,
    input  logic [1:0]       pc_taken_i,
    input  logic             icache_stall_i,
    input  logic             dcache_stall_i,
    output logic [1:0]       asel_o,
    output logic [1:0]       bsel_o,
    output logic [4:0]       stall_o,
    output logic [4:0]       flush_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam int         LCW     = (LU_CYCLES > 1) ? $clog2(LU_CYCLES) : 1;
    localparam logic [LCW-1:0] LU_LOAD = LCW'(LU_CYCLES - 1);
    localparam logic [4:0] REDIR_MASK = 5'((1 << (FLUSH_DEPTH + 1)) - 2);

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_LU    = 2'b01,
        S_DMISS = 2'b10
    } state_t;

    state_t           state_q;
    logic [LCW-1:0]   cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic [4:0] rs1_ex;
    logic [4:0] rs2_ex;
    logic [4:0] rd_mem;
    logic [4:0] rd_wb;
    logic [6:0] op_mem;

    assign rs1_ex = inst_ex_i[19:15];
    assign rs2_ex = inst_ex_i[24:20];
    assign rd_mem = inst_mem_i[11:7];
    assign rd_wb  = inst_wb_i[11:7];
    assign op_mem = inst_mem_i[6:0];

    logic unused_bits;
    assign unused_bits = ^{inst_ex_i[31:25], inst_ex_i[14:0],
                           inst_mem_i[31:12], inst_wb_i[31:12],
                           inst_wb_i[6:0]};

    logic mem_ok;
    logic wb_ok;
    logic lu_hit;
    logic redir;
    logic lu_act;
    logic redir_fire;

    assign mem_ok = regwen_mem_i && (rd_mem != 5'd0);
    assign wb_ok  = regwen_wb_i && (rd_wb != 5'd0);
    assign lu_hit = mem_ok && (op_mem == OP_LOAD)
                    && ((rs1_ex == rd_mem) || (rs2_ex == rd_mem));
    assign redir  = (pc_taken_i == 2'b01) || (pc_taken_i == 2'b10);
    assign lu_act = ((state_q == S_RUN) && lu_hit) || (state_q == S_LU);

    always_comb begin
        asel_o = 2'b00;
        bsel_o = 2'b00;
        if (!rst_i) begin
            if (mem_ok && (rs1_ex == rd_mem)) begin
                asel_o = 2'b01;
            end else if (wb_ok && (rs1_ex == rd_wb)) begin
                asel_o = 2'b10;
            end
            if (mem_ok && (rs2_ex == rd_mem)) begin
                bsel_o = 2'b01;
            end else if (wb_ok && (rs2_ex == rd_wb)) begin
                bsel_o = 2'b10;
            end
        end
    end

    // Priority: D-miss, load-use, redirect, I-miss.
    always_comb begin
        stall_o    = 5'b00000;
        flush_o    = 5'b00000;
        redir_fire = 1'b0;
        if (!rst_i) begin
            if (dcache_stall_i) begin
                stall_o = 5'b01111;
                flush_o = 5'b10000;
            end else if (lu_act) begin
                stall_o = 5'b00111;
                flush_o = 5'b01000;
            end else if (redir) begin
                stall_o    = {4'b0000, icache_stall_i};
                flush_o    = REDIR_MASK;
                redir_fire = 1'b1;
            end else if (icache_stall_i) begin
                stall_o = 5'b00001;
                flush_o = 5'b00010;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_o[0] && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redir_fire && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            unique case (state_q)
                S_RUN: begin
                    if (dcache_stall_i) begin
                        state_q <= S_DMISS;
                        cnt_q   <= '0;
                    end else if (lu_hit && (LU_CYCLES > 1)) begin
                        state_q <= S_LU;
                        cnt_q   <= LU_LOAD;
                    end
                end
                S_LU: begin
                    if (dcache_stall_i) begin
                        state_q <= S_DMISS;
                        cnt_q   <= '0;
                    end else if (cnt_q == LCW'(1)) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - LCW'(1);
                    end
                end
                S_DMISS: begin
                    if (!dcache_stall_i) begin
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign state_o     = rst_i ? 2'b00 : state_q;
    assign stall_cnt_o = rst_i ? '0 : stall_cnt_q;
    assign flush_cnt_o = rst_i ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: two configurations of hazard_ctrl_mc checked with
// vector tables, directed corner sequences and a random reference model.
module tb_hazard_ctrl_mc;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        regwen_mem;
    logic        regwen_wb;
    logic [31:0] inst_ex;
    logic [31:0] inst_mem;
    logic [31:0] inst_wb;
    logic [1:0]  pc_taken;
    logic        ic;
    logic        dc;

    logic [1:0] asel  [2];
    logic [1:0] bsel  [2];
    logic [4:0] stall [2];
    logic [4:0] flush [2];
    logic [1:0] state [2];
    logic [3:0]  sca, fca;
    logic [15:0] scb, fcb;

    hazard_ctrl_mc #(.LU_CYCLES(3), .FLUSH_DEPTH(3), .CNT_W(4)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .regwen_mem_i(regwen_mem), .regwen_wb_i(regwen_wb),
        .inst_ex_i(inst_ex), .inst_mem_i(inst_mem), .inst_wb_i(inst_wb),
        .pc_taken_i(pc_taken), .icache_stall_i(ic), .dcache_stall_i(dc),
        .asel_o(asel[0]), .bsel_o(bsel[0]),
        .stall_o(stall[0]), .flush_o(flush[0]), .state_o(state[0]),
        .stall_cnt_o(sca), .flush_cnt_o(fca)
    );

    hazard_ctrl_mc #(.LU_CYCLES(1), .FLUSH_DEPTH(2), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .regwen_mem_i(regwen_mem), .regwen_wb_i(regwen_wb),
        .inst_ex_i(inst_ex), .inst_mem_i(inst_mem), .inst_wb_i(inst_wb),
        .pc_taken_i(pc_taken), .icache_stall_i(ic), .dcache_stall_i(dc),
        .asel_o(asel[1]), .bsel_o(bsel[1]),
        .stall_o(stall[1]), .flush_o(flush[1]), .state_o(state[1]),
        .stall_cnt_o(scb), .flush_cnt_o(fcb)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 run, 1 load-use bubbles pending, 2 D-miss.
    int luc [2] = '{3, 1};
    int fdp [2] = '{3, 2};
    int cwd [2] = '{4, 16};
    int m_mode [2];
    int m_left [2];
    int m_sc   [2];
    int m_fc   [2];

    logic [1:0] e_asel  [2];
    logic [1:0] e_bsel  [2];
    logic [4:0] e_stall [2];
    logic [4:0] e_flush [2];
    bit         e_fire  [2];
    bit         e_lu;

    typedef struct {
        logic       mw;
        logic       ww;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rdm;
        logic [4:0] rdw;
        logic [1:0] ea;
        logic [1:0] eb;
    } fwd_vec_t;

    fwd_vec_t tbl [9];

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] r1,
                                       input logic [4:0] r2, input logic [6:0] op);
        return {7'd0, r2, r1, 3'd0, rd, op};
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rst) return 2'b00;
        if (regwen_mem && inst_mem[11:7] != 0 && rs == inst_mem[11:7]) return 2'b01;
        if (regwen_wb && inst_wb[11:7] != 0 && rs == inst_wb[11:7]) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_eval(input int k);
        logic [4:0] r1, r2, rdm;
        r1  = inst_ex[19:15];
        r2  = inst_ex[24:20];
        rdm = inst_mem[11:7];
        e_lu = regwen_mem && rdm != 0 && inst_mem[6:0] == OP_LOAD
               && (r1 == rdm || r2 == rdm);
        e_asel[k]  = ref_fwd(r1);
        e_bsel[k]  = ref_fwd(r2);
        e_stall[k] = 5'b0;
        e_flush[k] = 5'b0;
        e_fire[k]  = 1'b0;
        if (rst) begin
        end else if (dc) begin
            e_stall[k] = 5'b01111;
            e_flush[k] = 5'b10000;
        end else if ((m_mode[k] == 0 && e_lu) || m_mode[k] == 1) begin
            e_stall[k] = 5'b00111;
            e_flush[k] = 5'b01000;
        end else if (pc_taken == 2'b01 || pc_taken == 2'b10) begin
            for (int s = 1; s <= fdp[k]; s++) e_flush[k][s] = 1'b1;
            e_stall[k][0] = ic;
            e_fire[k] = 1'b1;
        end else if (ic) begin
            e_stall[k] = 5'b00001;
            e_flush[k] = 5'b00010;
        end
    endtask

    task automatic model_adv(input int k);
        int mx;
        mx = (1 << cwd[k]) - 1;
        if (rst) begin
            m_mode[k] = 0; m_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end else begin
            if (e_stall[k][0] && m_sc[k] < mx) m_sc[k]++;
            if (e_fire[k] && m_fc[k] < mx) m_fc[k]++;
            if (m_mode[k] == 2) begin
                m_mode[k] = dc ? 2 : 0;
            end else if (dc) begin
                m_mode[k] = 2; m_left[k] = 0;
            end else if (m_mode[k] == 0) begin
                if (e_lu && luc[k] > 1) begin
                    m_mode[k] = 1; m_left[k] = luc[k] - 1;
                end
            end else if (m_left[k] == 1) begin
                m_mode[k] = 0; m_left[k] = 0;
            end else begin
                m_left[k]--;
            end
        end
    endtask

    task automatic settle();
        int asc, afc;
        string p;
        #2;
        for (int k = 0; k < 2; k++) begin
            model_eval(k);
            p   = (k == 0) ? "a" : "b";
            asc = (k == 0) ? int'(sca) : int'(scb);
            afc = (k == 0) ? int'(fca) : int'(fcb);
            check({p, ".asel"},  32'(asel[k]),  32'(e_asel[k]));
            check({p, ".bsel"},  32'(bsel[k]),  32'(e_bsel[k]));
            check({p, ".stall"}, 32'(stall[k]), 32'(e_stall[k]));
            check({p, ".flush"}, 32'(flush[k]), 32'(e_flush[k]));
            check({p, ".state"}, 32'(state[k]), rst ? 32'd0 : 32'(m_mode[k]));
            check({p, ".scnt"},  32'(asc),      rst ? 32'd0 : 32'(m_sc[k]));
            check({p, ".fcnt"},  32'(afc),      rst ? 32'd0 : 32'(m_fc[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_adv(k);
        @(negedge clk);
    endtask

    task automatic clear_in();
        regwen_mem = 0; regwen_wb = 0;
        inst_ex = 32'd0; inst_mem = 32'd0; inst_wb = 32'd0;
        pc_taken = 2'b00; ic = 0; dc = 0;
    endtask

    initial begin
        int fb0, fa0;
        tbl[0] = '{1, 0, 5, 7, 5, 0, 2'b01, 2'b00};
        tbl[1] = '{1, 1, 5, 7, 5, 5, 2'b01, 2'b00};
        tbl[2] = '{1, 1, 5, 7, 0, 5, 2'b10, 2'b00};
        tbl[3] = '{0, 1, 5, 7, 5, 5, 2'b10, 2'b00};
        tbl[4] = '{1, 0, 3, 5, 5, 0, 2'b00, 2'b01};
        tbl[5] = '{1, 1, 5, 5, 5, 5, 2'b01, 2'b01};
        tbl[6] = '{1, 1, 0, 0, 0, 0, 2'b00, 2'b00};
        tbl[7] = '{0, 1, 9, 9, 4, 9, 2'b10, 2'b10};
        tbl[8] = '{1, 0, 9, 9, 4, 9, 2'b00, 2'b00};
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end

        clear_in();
        rst = 1;
        @(negedge clk);
        settle(); tick();
        settle(); tick();
        rst = 0;
        settle();
        check("reset.state_a", 32'(state[0]), 32'd0);
        check("reset.scnt_a", 32'(sca), 32'd0);
        tick();

        // Forwarding vectors
        for (int i = 0; i < 9; i++) begin
            regwen_mem = tbl[i].mw;
            regwen_wb  = tbl[i].ww;
            inst_ex    = mk(5'd0, tbl[i].rs1, tbl[i].rs2, OP_ADD);
            inst_mem   = mk(tbl[i].rdm, 5'd0, 5'd0, OP_ADD);
            inst_wb    = mk(tbl[i].rdw, 5'd0, 5'd0, OP_ADD);
            settle();
            for (int k = 0; k < 2; k++) begin
                check($sformatf("tbl%0d.asel", i), 32'(asel[k]), 32'(tbl[i].ea));
                check($sformatf("tbl%0d.bsel", i), 32'(bsel[k]), 32'(tbl[i].eb));
            end
            tick();
        end

        // Load-use: 3 bubbles on dut_a, load leaves MEM after first cycle
        clear_in();
        regwen_mem = 1;
        inst_mem = mk(5'd6, 5'd1, 5'd0, OP_LOAD);
        inst_ex  = mk(5'd8, 5'd2, 5'd6, OP_ADD);
        for (int c = 0; c < 4; c++) begin
            settle();
            check($sformatf("lu%0d.stall", c), 32'(stall[0]), (c < 3) ? 32'h07 : 32'h00);
            check($sformatf("lu%0d.flush", c), 32'(flush[0]), (c < 3) ? 32'h08 : 32'h00);
            check($sformatf("lu%0d.state", c), 32'(state[0]),
                  (c == 1 || c == 2) ? 32'd1 : 32'd0);
            tick();
            regwen_mem = 0;
            inst_mem = 32'd0;
        end

        // D-miss hides a pending redirect until it clears
        clear_in();
        dc = 1;
        pc_taken = 2'b01;
        fb0 = int'(fcb);
        for (int c = 0; c < 4; c++) begin
            settle();
            check("dmiss.stall", 32'(stall[1]), 32'h0F);
            check("dmiss.flush", 32'(flush[1]), 32'h10);
            tick();
        end
        check("dmiss.fcnt_hold", 32'(fcb), 32'(fb0));
        dc = 0;
        settle();
        check("redir.flush_b", 32'(flush[1]), 32'h06);
        check("redir.flush_a", 32'(flush[0]), 32'h0E);
        tick();
        check("redir.fcnt_b", 32'(fcb), 32'(fb0 + 1));

        // Redirect with concurrent I-miss, depth 3
        pc_taken = 2'b10;
        ic = 1;
        fa0 = int'(fca);
        settle();
        check("redir_ic.flush", 32'(flush[0]), 32'h0E);
        check("redir_ic.stall", 32'(stall[0]), 32'h01);
        tick();
        check("redir_ic.fcnt", 32'(fca), 32'((fa0 + 1) > 15 ? 15 : fa0 + 1));

        // Reset mid load-use
        clear_in();
        regwen_mem = 1;
        inst_mem = mk(5'd6, 5'd0, 5'd0, OP_LOAD);
        inst_ex  = mk(5'd0, 5'd6, 5'd0, OP_ADD);
        settle(); tick();
        check("rst_lu.pre_state", 32'(state[0]), 32'd1);
        rst = 1;
        settle();
        check("rst_lu.asel", 32'(asel[0]), 32'd0);
        check("rst_lu.stall", 32'(stall[0]), 32'd0);
        check("rst_lu.flush", 32'(flush[0]), 32'd0);
        tick();
        rst = 0;
        clear_in();
        settle();
        check("rst_lu.state", 32'(state[0]), 32'd0);
        check("rst_lu.scnt", 32'(sca), 32'd0);
        check("rst_lu.fcnt", 32'(fca), 32'd0);
        tick();

        // Stall counter saturation at 4 bits
        ic = 1;
        for (int c = 0; c < 20; c++) begin
            settle(); tick();
        end
        settle();
        check("sat.scnt_a", 32'(sca), 32'd15);
        check("sat.scnt_b", 32'(scb), 32'd20);
        tick();

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 39) == 0);
            regwen_mem = 1'($urandom_range(0, 1));
            regwen_wb  = 1'($urandom_range(0, 1));
            inst_ex  = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), OP_ADD);
            inst_mem = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          ($urandom_range(0, 1) == 1) ? OP_LOAD : OP_ADD);
            inst_wb  = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), OP_ADD);
            pc_taken = 2'($urandom_range(0, 3));
            ic = ($urandom_range(0, 3) == 0);
            dc = ($urandom_range(0, 5) == 0);
            settle();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
